// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg -- constants and types shared by the instruction fetch front end.
//   INST_NOP / BUBBLE_PC : values the decode slot shows when no instruction is buffered
//   FS_IDLE/FS_WAIT/FS_DROP : fetch state encodings
//   fetch_entry_t        : one buffered instruction, {pc, inst}
//   align_word()         : clears the byte-offset bits of an address
package fetch_stage_pkg;

  localparam logic [31:0] INST_NOP  = 32'h00000013;
  localparam logic [31:0] BUBBLE_PC = 32'hffffffff;

  // IDLE: nothing outstanding; WAIT: response will be kept; DROP: response will be discarded
  localparam logic [1:0] FS_IDLE = 2'd0;
  localparam logic [1:0] FS_WAIT = 2'd1;
  localparam logic [1:0] FS_DROP = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hffff_fffc;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo -- small instruction buffer between fetch and decode.
//   clk, reset : clock and synchronous active-high reset
//   push       : write push_data at the tail (ignored when full and not popping)
//   pop        : drop the head entry (ignored when empty)
//   clear      : empty the buffer; wins over push and pop
//   full/empty : occupancy flags
//   count      : number of valid entries (0..FIFO_DEPTH)
//   head       : oldest entry, valid while !empty
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter  int FIFO_DEPTH = 2,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             clear,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;
  fetch_entry_t     entries [FIFO_DEPTH];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // One register per slot; only the slot under the write pointer loads.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      fetch_entry_t data_reg;
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
          data_reg <= push_data;
        end
      end
      assign entries[gi] = data_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign head  = entries[rd_ptr_reg];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch front end: owns the PC, issues one-word reads
// (at most one outstanding) and buffers returned words toward decode.
//   clk, reset                     : clock, synchronous active-high reset
//   branch_hazard, branch_target   : redirect from writeback (flush + new PC)
//   mem_start, mem_addr, mem_ready : instruction read request handshake
//   mem_rvalid, mem_rdata          : in-order read response
//   inst_valid, inst, inst_pc      : decode slot (NOP / BUBBLE_PC when empty)
//   inst_ready                     : decode consumes the head this cycle
//   perf_fetch_count               : words pushed into the buffer
//   perf_discard_count             : responses squashed by a redirect
// Build option: define FETCH_PERF_EN to enable the saturating perf counters;
// otherwise both counter ports are tied to zero.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_hazard,
  input  logic [31:0] branch_target,
  output logic        mem_start,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic [31:0] perf_fetch_count,
  output logic [31:0] perf_discard_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic [31:0]      req_pc_reg;
  logic             accept;
  logic             fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;

  // Issue depends only on registered state and the redirect, never on inst_ready.
  assign mem_start = !reset && (state_reg == FS_IDLE) && !branch_hazard &&
                     (fifo_count < CNT_W'(FIFO_DEPTH));
  assign mem_addr  = pc_reg;
  assign accept    = mem_start && mem_ready;

  // A request is only issued with room to spare, so the full guard never
  // blocks a legitimate response; it just keeps the buffer safe.
  assign fifo_push  = (state_reg == FS_WAIT) && mem_rvalid && !branch_hazard && !fifo_full;
  assign fifo_pop   = !fifo_empty && inst_ready && !branch_hazard;
  assign push_entry = '{pc: req_pc_reg, inst: mem_rdata};

  fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .clear     (branch_hazard),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FS_IDLE: if (accept) state_next = FS_WAIT;
      // A response arriving together with a redirect is simply dropped,
      // so the machine returns to IDLE rather than waiting in DROP.
      FS_WAIT: begin
        if (mem_rvalid)         state_next = FS_IDLE;
        else if (branch_hazard) state_next = FS_DROP;
      end
      FS_DROP: if (mem_rvalid) state_next = FS_IDLE;
      default: state_next = FS_IDLE;
    endcase
  end

  always_comb begin
    pc_next = pc_reg;
    if (branch_hazard) pc_next = align_word(branch_target);
    else if (accept)   pc_next = pc_reg + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= FS_IDLE;
      pc_reg     <= RESET_PC;
      req_pc_reg <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (accept) req_pc_reg <= pc_reg;
    end
  end

  assign inst_valid = !fifo_empty;
  assign inst       = fifo_empty ? INST_NOP  : fifo_head.inst;
  assign inst_pc    = fifo_empty ? BUBBLE_PC : fifo_head.pc;

`ifdef FETCH_PERF_EN
  logic        discard;
  logic [31:0] fetch_cnt_reg;
  logic [31:0] discard_cnt_reg;

  assign discard = mem_rvalid &&
                   ((state_reg == FS_DROP) || ((state_reg == FS_WAIT) && branch_hazard));

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_reg   <= '0;
      discard_cnt_reg <= '0;
    end else begin
      if (fifo_push && (fetch_cnt_reg != 32'hffffffff))
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      if (discard && (discard_cnt_reg != 32'hffffffff))
        discard_cnt_reg <= discard_cnt_reg + 32'd1;
    end
  end

  assign perf_fetch_count   = fetch_cnt_reg;
  assign perf_discard_count = discard_cnt_reg;
`else
  assign perf_fetch_count   = 32'd0;
  assign perf_discard_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage -- directed self-checking bench for fetch_stage.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5A5A5;
`ifdef FETCH_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_hazard;
  logic [31:0] branch_target;
  logic        mem_start;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [31:0] perf_fetch_count;
  logic [31:0] perf_discard_count;

  int check_cnt = 0;
  int error_cnt = 0;
  bit auto_mem  = 1'b0;
  int n;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk                (clk),
    .reset              (reset),
    .branch_hazard      (branch_hazard),
    .branch_target      (branch_target),
    .mem_start          (mem_start),
    .mem_addr           (mem_addr),
    .mem_ready          (mem_ready),
    .mem_rvalid         (mem_rvalid),
    .mem_rdata          (mem_rdata),
    .inst_valid         (inst_valid),
    .inst               (inst),
    .inst_pc            (inst_pc),
    .inst_ready         (inst_ready),
    .perf_fetch_count   (perf_fetch_count),
    .perf_discard_count (perf_discard_count)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  function automatic logic [31:0] perf_exp(input int cnt);
    return PERF_ON ? 32'(cnt) : 32'd0;
  endfunction

  // One clock; in auto mode the memory answers the cycle after each accept
  // with rdata = addr ^ KEY.
  task automatic tick();
    logic        acc;
    logic [31:0] addr;
    @(negedge clk);
    acc  = mem_start && mem_ready;
    addr = mem_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      mem_rvalid = acc;
      mem_rdata  = addr ^ KEY;
    end
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    branch_hazard = 1'b0;
    branch_target = 32'h0;
    mem_rvalid    = 1'b0;
    mem_rdata     = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; branch_hazard = 1'b0; branch_target = 32'h0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0; inst_ready = 1'b1;

    // ---- reset state ----
    tick(); tick(); #1;
    check_value("rst_start",   32'(mem_start), 32'd0);
    check_value("rst_valid",   32'(inst_valid), 32'd0);
    check_value("rst_inst",    inst, INST_NOP);
    check_value("rst_pc",      inst_pc, BUBBLE_PC);
    check_value("rst_addr",    mem_addr, 32'h0);
    check_value("rst_fetch",   perf_fetch_count, 32'd0);
    check_value("rst_discard", perf_discard_count, 32'd0);

    // ---- streaming: one word every two cycles ----
    auto_mem = 1'b1; mem_ready = 1'b1; inst_ready = 1'b1;
    do_reset();
    n = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      check_value("stream_start", 32'(mem_start), 32'((cyc % 2) == 0));
      if ((cyc % 2) == 0) check_value("stream_addr", mem_addr, 32'(2 * cyc));
      if (inst_valid) begin
        check_value("stream_pc",   inst_pc, 32'(4 * n));
        check_value("stream_inst", inst, 32'(4 * n) ^ KEY);
        check_value("stream_slot", 32'(cyc), 32'(2 + 2 * n));
        n++;
      end
      tick(); #1;
    end
    check_value("stream_words", 32'(n), 32'd4);
    check_value("stream_fetch", perf_fetch_count, perf_exp(5));

    // ---- backpressure: buffer fills after two words ----
    inst_ready = 1'b0;
    do_reset();
    repeat (4) begin tick(); #1; end
    check_value("bp_start_c4", 32'(mem_start), 32'd0);
    check_value("bp_addr_c4",  mem_addr, 32'h8);
    check_value("bp_pc_c4",    inst_pc, 32'h0);
    repeat (2) begin tick(); #1; end
    check_value("bp_start_c6", 32'(mem_start), 32'd0);
    check_value("bp_inst_c6",  inst, 32'h0 ^ KEY);
    inst_ready = 1'b1; #1;
    check_value("bp_no_comb",  32'(mem_start), 32'd0);
    tick(); #1;
    check_value("bp_pc_next",  inst_pc, 32'h4);
    check_value("bp_inst_next", inst, 32'h4 ^ KEY);
    check_value("bp_resume",   32'(mem_start), 32'd1);
    check_value("bp_resume_addr", mem_addr, 32'h8);

    // ---- flush with a read in flight ----
    auto_mem = 1'b0; inst_ready = 1'b0;
    do_reset();
    tick(); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_1111; #1;
    tick(); mem_rvalid = 1'b0; #1;
    check_value("fl_pc0",     inst_pc, 32'h0);
    check_value("fl_addr4",   mem_addr, 32'h4);
    tick(); #1;
    check_value("fl_held",    32'(inst_valid), 32'd1);
    branch_hazard = 1'b1; branch_target = 32'h100; #1;
    check_value("fl_no_issue", 32'(mem_start), 32'd0);
    tick(); branch_hazard = 1'b0; #1;
    check_value("fl_empty",   32'(inst_valid), 32'd0);
    check_value("fl_bubble",  inst_pc, BUBBLE_PC);
    check_value("fl_nop",     inst, INST_NOP);
    check_value("fl_drop_wait", 32'(mem_start), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_2222; #1;
    tick(); mem_rvalid = 1'b0; #1;
    check_value("fl_start",   32'(mem_start), 32'd1);
    check_value("fl_target",  mem_addr, 32'h100);
    check_value("fl_still_empty", 32'(inst_valid), 32'd0);
    check_value("fl_discard", perf_discard_count, perf_exp(1));
    check_value("fl_fetch",   perf_fetch_count, perf_exp(1));

    // ---- hazard and response in the same cycle ----
    tick(); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_DEAD;
    branch_hazard = 1'b1; branch_target = 32'h40; #1;
    tick(); mem_rvalid = 1'b0; branch_hazard = 1'b0; #1;
    check_value("sc_no_push", 32'(inst_valid), 32'd0);
    check_value("sc_idle",    32'(mem_start), 32'd1);
    check_value("sc_addr",    mem_addr, 32'h40);
    check_value("sc_discard", perf_discard_count, perf_exp(2));
    tick(); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_1234; #1;
    tick(); mem_rvalid = 1'b0; #1;
    check_value("sc_pc",      inst_pc, 32'h40);
    check_value("sc_inst",    inst, 32'h0000_1234);
    check_value("sc_fetch",   perf_fetch_count, perf_exp(2));

    // ---- misaligned redirect target ----
    branch_hazard = 1'b1; branch_target = 32'h00000106; #1;
    check_value("mis_no_issue", 32'(mem_start), 32'd0);
    tick(); branch_hazard = 1'b0; #1;
    check_value("mis_addr",   mem_addr, 32'h104);
    check_value("mis_start",  32'(mem_start), 32'd1);
    check_value("mis_flush",  32'(inst_valid), 32'd0);

    // ---- reset with a full buffer ----
    auto_mem = 1'b1; inst_ready = 1'b0;
    do_reset();
    repeat (5) begin tick(); #1; end
    check_value("rf_full_valid", 32'(inst_valid), 32'd1);
    check_value("rf_full_block", 32'(mem_start), 32'd0);
    check_value("rf_fetch",      perf_fetch_count, perf_exp(2));
    reset = 1'b1; #1;
    tick(); #1;
    check_value("rf_valid",   32'(inst_valid), 32'd0);
    check_value("rf_inst",    inst, INST_NOP);
    check_value("rf_pc",      inst_pc, BUBBLE_PC);
    check_value("rf_addr",    mem_addr, 32'h0);
    check_value("rf_fetch0",  perf_fetch_count, 32'd0);
    check_value("rf_disc0",   perf_discard_count, 32'd0);
    reset = 1'b0; #1;
    check_value("rf_restart", 32'(mem_start), 32'd1);

    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end

endmodule
